// File: rtl/psram_ui_pkg.sv
// Shared types and defaults for the PSRAM user-interface responder.
package psram_ui_pkg;

  localparam int DEF_ADDR_W       = 21;
  localparam int DEF_DATA_W       = 64;
  localparam int DEF_BURST        = 8;
  localparam int DEF_MEM_AW       = 10;
  localparam int DEF_CALIB_CYCLES = 64;
  localparam int DEF_RD_LATENCY   = 12;
  localparam int DEF_CMD_GAP      = 22;

  typedef enum logic [2:0] {
    S_CALIB,
    S_IDLE,
    S_WRITE,
    S_RD_WAIT,
    S_RD_BURST,
    S_GAP
  } state_t;

  // Byte lanes in one beat.
  function automatic int mask_w(input int data_w);
    return data_w / 8;
  endfunction

  // Bits needed to index a beat inside a burst.
  function automatic int beat_w(input int burst);
    return $clog2(burst);
  endfunction

endpackage

// File: rtl/psram_ui_mem.sv
// Single-port byte-enabled backing RAM with a registered read port.
module psram_ui_mem #(
  parameter int DATA_W = 64,
  parameter int MEM_AW = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [MEM_AW-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  output logic [DATA_W-1:0]     o_rdata
);
  localparam int MASK_W = DATA_W / 8;

  // Storage is deliberately not reset so contents survive a user reset.
  logic [MASK_W-1:0][7:0] r_mem [0:(1<<MEM_AW)-1];
  logic [DATA_W-1:0]      r_rdata;

  // Byte-lane write, only enabled lanes are touched.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < MASK_W; b++) begin
      if (i_we && i_be[b]) r_mem[i_addr][b] <= i_wdata[b*8 +: 8];
    end
  end

  // Registered read; output holds between reads and clears on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/psram_ui_responder.sv
// Cycle-accurate stand-in for the PSRAM HS controller user interface.
module psram_ui_responder
  import psram_ui_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BURST        = DEF_BURST,
  parameter int MEM_AW       = DEF_MEM_AW,
  parameter int CALIB_CYCLES = DEF_CALIB_CYCLES,
  parameter int RD_LATENCY   = DEF_RD_LATENCY,
  parameter int CMD_GAP      = DEF_CMD_GAP
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cmd,
  input  logic                       i_cmd_en,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [mask_w(DATA_W)-1:0]  i_data_mask,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_rd_data_valid,
  output logic                       o_init_calib,
  output logic                       o_cmd_drop
);
  localparam int MASK_W = mask_w(DATA_W);
  localparam int BEAT_W = beat_w(BURST);
  localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);
  localparam int LAT_W  = $clog2(RD_LATENCY + 1);
  localparam int GAP_W  = $clog2(CMD_GAP + 1);
  localparam int BASE_W = MEM_AW - BEAT_W;

  state_t              r_state;
  logic [CAL_W-1:0]    r_cal;
  logic [LAT_W-1:0]    r_lat;
  logic [GAP_W-1:0]    r_gap;
  logic [BEAT_W-1:0]   r_beat;
  logic [BASE_W-1:0]   r_base;
  logic                r_valid;
  logic                r_init;
  logic                r_drop;

  logic                w_accept;
  logic                w_we;
  logic                w_re;
  logic [BASE_W-1:0]   w_base;
  logic [MEM_AW-1:0]   w_maddr;
  logic                w_unused_addr;

  // Burst-offset bits and aliased high bits do not select storage.
  assign w_unused_addr = ^{i_addr[ADDR_W-1:MEM_AW], i_addr[BEAT_W-1:0]};

  // Beat 0 of a write goes straight to RAM on the accept cycle; r_beat is
  // zero in IDLE and RD_WAIT, so the same address mux serves every beat.
  assign w_accept = !i_rst && i_cmd_en && (r_state == S_IDLE);
  assign w_we     = !i_rst && ((w_accept && i_cmd) || (r_state == S_WRITE));
  assign w_re     = !i_rst && (((r_state == S_RD_WAIT) && (r_lat == '0)) ||
                               (r_state == S_RD_BURST));
  assign w_base   = w_accept ? i_addr[MEM_AW-1:BEAT_W] : r_base;
  assign w_maddr  = {w_base, r_beat};

  psram_ui_mem #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_be    (~i_data_mask),
    .i_addr  (w_maddr),
    .i_wdata (i_wr_data),
    .i_re    (w_re),
    .o_rdata (o_rd_data)
  );

  // Command FSM with calibration, latency, gap and beat counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_CALIB;
      r_cal   <= '0;
      r_lat   <= '0;
      r_gap   <= '0;
      r_beat  <= '0;
      r_base  <= '0;
      r_valid <= 1'b0;
      r_init  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop  <= i_cmd_en && (r_state != S_IDLE);
      r_valid <= w_re;
      if (r_gap != '0) r_gap <= r_gap - 1'b1;
      case (r_state)
        S_CALIB: begin
          if (r_cal == CAL_W'(CALIB_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_init  <= 1'b1;
          end else begin
            r_cal <= r_cal + 1'b1;
          end
        end
        S_IDLE: begin
          if (i_cmd_en) begin
            r_base <= i_addr[MEM_AW-1:BEAT_W];
            r_gap  <= GAP_W'(CMD_GAP - 1);
            if (i_cmd) begin
              r_beat  <= BEAT_W'(1);
              r_state <= S_WRITE;
            end else begin
              // Two cycles of the latency are the issue cycle and RAM read.
              r_lat   <= LAT_W'(RD_LATENCY - 2);
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_WRITE, S_RD_BURST: begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == BEAT_W'(BURST - 1)) r_state <= S_GAP;
        end
        S_RD_WAIT: begin
          if (r_lat == '0) begin
            r_beat  <= BEAT_W'(1);
            r_state <= S_RD_BURST;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap <= GAP_W'(1)) r_state <= S_IDLE;
        end
        default: r_state <= S_CALIB;
      endcase
    end
  end

  assign o_rd_data_valid = r_valid;
  assign o_init_calib    = r_init;
  assign o_cmd_drop      = r_drop;

endmodule

// File: tb/tb_psram_ui_responder.sv
// Randomized scoreboard bench for psram_ui_responder against a cycle-level
// behavioural model of the user interface.
module tb_psram_ui_responder;
  localparam int ADDR_W = 21, DATA_W = 64, BURST = 8, MEM_AW = 10;
  localparam int CALIB_CYCLES = 64, RD_LATENCY = 12, CMD_GAP = 22;
  localparam int WORDS = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst, cmd, cmd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [7:0]        data_mask;
  logic              rd_data_valid, init_calib, cmd_drop;

  psram_ui_responder dut (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_cmd_en(cmd_en), .i_addr(addr),
    .i_wr_data(wr_data), .i_data_mask(data_mask), .o_rd_data(rd_data),
    .o_rd_data_valid(rd_data_valid), .o_init_calib(init_calib),
    .o_cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  typedef struct { int at; logic [DATA_W-1:0] data; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  bit rst_hist[int];
  bit drop_exp[int];

  // Reference model state.
  logic [DATA_W-1:0] mmem [WORDS];
  int low_run  = 0;
  int last_acc = -1000;
  int wr_left  = 0, wr_k = 0, wr_a = 0;
  logic [DATA_W-1:0] wd [BURST];
  logic [7:0]        wm [BURST];

  task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int word_of(input int a, input int k);
    return ((a / BURST) * BURST + k) % WORDS;
  endfunction

  task automatic apply_beat(input int a, input int k, input logic [DATA_W-1:0] d,
                            input logic [7:0] m);
    int w;
    w = word_of(a, k);
    for (int b = 0; b < 8; b++) if (!m[b]) mmem[w][b*8 +: 8] = d[b*8 +: 8];
  endtask

  function automatic bit ready();
    return (low_run >= CALIB_CYCLES) && (cyc + 1 >= last_acc + CMD_GAP);
  endfunction

  // Present one cycle of inputs, update the model for the coming edge, clock.
  task automatic drive(input bit r, input bit en, input bit wr,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [7:0] m);
    int e;
    e = cyc + 1;
    rst = r; cmd_en = en; cmd = wr; addr = a; wr_data = d; data_mask = m;
    rst_hist[e] = r;
    if (r) begin
      wr_left = 0;
      while (q.size() > 0 && q[q.size()-1].at >= e) void'(q.pop_back());
    end else begin
      if (wr_left > 0) begin
        apply_beat(wr_a, wr_k, d, m);
        wr_k++; wr_left--;
      end
      if (en) begin
        if (ready()) begin
          last_acc = e;
          if (wr) begin
            wr_a = int'(a);
            apply_beat(wr_a, 0, d, m);
            wr_k = 1; wr_left = BURST - 1;
          end else begin
            for (int k = 0; k < BURST; k++)
              q.push_back('{e + RD_LATENCY - 1 + k, mmem[word_of(int'(a), k)]});
          end
        end else begin
          drop_exp[e] = 1'b1;
        end
      end
    end
    @(posedge clk);
    cyc++;
    low_run = r ? 0 : low_run + 1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'($urandom), ADDR_W'($urandom), {$urandom, $urandom},
          8'($urandom));
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && !ready(); i++) idle();
  endtask

  task automatic issue_wr(input logic [ADDR_W-1:0] a);
    wait_ready();
    drive(1'b0, 1'b1, 1'b1, a, wd[0], wm[0]);
    for (int k = 1; k < BURST; k++)
      drive(1'b0, 1'b0, 1'($urandom), ADDR_W'($urandom), wd[k], wm[k]);
  endtask

  task automatic issue_rd(input logic [ADDR_W-1:0] a);
    wait_ready();
    drive(1'b0, 1'b1, 1'b0, a, {$urandom, $urandom}, 8'($urandom));
  endtask

  // Output monitor: compares the registered outputs after every edge.
  int mlow = 0;
  logic [DATA_W-1:0] hold = '0;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_hist[cyc]) begin mlow = 0; hold = '0; end
      else mlow++;
      chk("init_calib", 64'(init_calib), 64'(mlow >= CALIB_CYCLES));
      chk("cmd_drop", 64'(cmd_drop), 64'(drop_exp.exists(cyc)));
      while (q.size() > 0 && q[0].at < cyc) begin
        chk("rd_valid_missing", 64'(0), 64'(1));
        void'(q.pop_front());
      end
      if (rd_data_valid === 1'b1) begin
        if (q.size() == 0 || q[0].at != cyc) begin
          chk("rd_valid_unexpected", 64'(1), 64'(0));
        end else begin
          chk("rd_data", rd_data, q[0].data);
          hold = q[0].data;
          void'(q.pop_front());
        end
      end else begin
        if (q.size() > 0 && q[0].at == cyc) begin
          chk("rd_valid_missing", 64'(rd_data_valid), 64'(1));
          void'(q.pop_front());
        end
        chk("rd_data_hold", rd_data, hold);
      end
    end
  end

  initial begin
    int t;
    // Reset, then calibration with early commands dropped.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 70; i++)
      drive(1'b0, (i == 10) || (i == 63), 1'b0, '0, '0, '0);

    // Full write then readback at address 0.
    for (int k = 0; k < BURST; k++) begin
      wd[k] = 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
      wm[k] = 8'h00;
    end
    issue_wr('0);
    issue_rd('0);

    // Byte mask over an all-ones block.
    for (int k = 0; k < BURST; k++) begin wd[k] = '1; wm[k] = 8'h00; end
    issue_wr(21'd8);
    for (int k = 0; k < BURST; k++) begin wd[k] = '0; wm[k] = 8'h0f; end
    issue_wr(21'd8);
    issue_rd(21'd8);

    // Gap: one cycle early is dropped, exactly on the gap is accepted.
    issue_rd('0);
    t = cyc;
    while (cyc < t + CMD_GAP - 2) idle();
    drive(1'b0, 1'b1, 1'b0, 21'd8, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 21'd8, '0, '0);

    // Aliasing and alignment: 0x403 lands on words 0..7.
    for (int k = 0; k < BURST; k++) begin wd[k] = {$urandom, $urandom}; wm[k] = 8'h00; end
    issue_wr(21'h403);
    issue_rd('0);

    // Reset in the middle of a read burst, then memory persistence.
    issue_rd('0);
    t = cyc;
    while (cyc < t + 13) idle();
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    issue_rd('0);
    issue_rd(21'd8);

    // Fill all backing words through aliased, misaligned addresses.
    for (int b = 0; b < WORDS / BURST; b++) begin
      for (int k = 0; k < BURST; k++) begin wd[k] = {$urandom, $urandom}; wm[k] = 8'h00; end
      issue_wr({ADDR_W'($urandom_range(0, 2047)), 10'(b * BURST)} | ADDR_W'($urandom_range(0, 7)));
    end

    // Random traffic: commands at any time, random masks, rare resets.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 999) < 2, $urandom_range(0, 5) == 0, 1'($urandom),
            ADDR_W'($urandom), {$urandom, $urandom}, 8'($urandom));
    end

    for (int i = 0; i < 40; i++) idle();
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_ui_responder.md
# psram_ui_responder

Cycle-accurate responder for the PSRAM HS controller user interface (cmd/cmd_en/addr/wr_data/data_mask in, rd_data/rd_data_valid/init_calib out), backed by on-chip byte-enabled RAM. It sits where the controller IP sits, so the SPI-side writer and the HDMI-side reader can be simulated and brought up on hardware without the IP or the PSRAM die. It emulates calibration delay, 8-beat write/read bursts, read latency and the command-to-command gap.

## Interface
- ADDR_W, 21: command address width, in 64-bit word units.
- DATA_W, 64: beat width. Must be a multiple of 8.
- BURST, 8: beats per command. Must be a power of 2.
- MEM_AW, 10: log2 of backing words. Higher address bits alias.
- CALIB_CYCLES, 64: cycles from reset release to init_calib.
- RD_LATENCY, 12: cycles from read cmd_en to first rd_data_valid.
- CMD_GAP, 22: minimum cycles between accepted commands. Must satisfy CMD_GAP >= RD_LATENCY+BURST.
- clk  in  1: user clock (the controller's clk_out domain).
- rst  in  1: synchronous, active-high reset.
- cmd  in  1: 1 = write, 0 = read.
- cmd_en  in  1: command strobe, single cycle.
- addr  in  ADDR_W: burst start address. Low log2(BURST) bits are ignored (burst-aligned).
- wr_data  in  DATA_W: write beat.
- data_mask  in  DATA_W/8: bit i = 1 blocks byte i.
- rd_data  out  DATA_W: read beat.
- rd_data_valid  out  1: rd_data qualifier.
- init_calib  out  1: ready for commands.
- cmd_drop  out  1: one-cycle pulse when a cmd_en is ignored.

## Operation
- States:
  - CALIB: counts CALIB_CYCLES, then goes to IDLE and sets init_calib.
  - IDLE: waits for a command.
  - WRITE: captures beats 1..BURST-1.
  - RD_WAIT, then RD_BURST: return read data.
  - GAP: waits for the gap counter to expire, then returns to IDLE.
- Accept: cmd_en=1 and state IDLE. Any other cmd_en (CALIB, WRITE, RD_*, GAP) → cmd_drop=1 the next cycle; the command has no effect.
- Write accepted at cycle T:
  - Beat k (k=0..BURST-1) is sampled at cycle T+k from wr_data/data_mask and written to word (addr aligned + k) mod 2^MEM_AW.
  - Masked bytes are left unchanged.
  - wr_data/data_mask are ignored (may be X/Z) outside these cycles.
- Read accepted at cycle T:
  - rd_data_valid=1 on cycles T+RD_LATENCY .. T+RD_LATENCY+BURST-1, with beat k on cycle T+RD_LATENCY+k.
  - Data reflects memory contents as of cycle T. A prior write burst is always complete, given the gap.
- Gap: the next command is accepted no earlier than cycle T+CMD_GAP. The gap counter is loaded at accept.
- rd_data holds its last value when not valid.
- Memory is a BRAM-inferable array, not reset; contents survive rst.

## Timing
- Reset values: init_calib=0, rd_data_valid=0, rd_data=0, cmd_drop=0, state CALIB.
- init_calib rises exactly CALIB_CYCLES cycles after the first cycle with rst=0.
- Memory read path: registered, 1-cycle RAM. The read address is issued at T+RD_LATENCY-1+k, so rd_data is registered output.
- Reset mid-burst: the next cycle has rd_data_valid=0 and init_calib=0. Remaining write beats are discarded; already-written beats persist.
- cmd_en with rst=1 is ignored, with no cmd_drop.
- Address arithmetic: beat index is added modulo BURST within the aligned block, then truncated to MEM_AW bits.

## Structure
- Package psram_ui_pkg:
  - State enum.
  - Width helpers: MASK_W = DATA_W/8, BEAT_W = $clog2(BURST).
  - Default parameter constants.
- Sub-module psram_ui_mem: single-port byte-enable RAM, 1-cycle registered read, DATA_W × 2^MEM_AW.
- The FSM, calibration counter, gap counter, beat counter and read latency counter live in the top.

## Test plan
- Calibration:
  - Release rst at cycle 0 → init_calib=1 at cycle 64.
  - cmd_en at cycle 10 → cmd_drop at cycle 11.
  - No rd_data_valid at any point.
- Full write/readback:
  - Write at addr 0 with beats 64'h0706050403020100 … 64'h3f3e3d3c3b3a3938 (+0x0808... per beat), mask 0.
  - Read addr 0 at T → valid on T+12..T+19 with the same 8 beats in order.
- Byte mask:
  - Pre-fill addr 8 with all-ones words.
  - Write with data_mask=8'h0f, data 0.
  - Readback → every beat = 64'h00000000ffffffff.
- Gap enforcement:
  - Read at T, then cmd_en at T+21 → cmd_drop, ignored.
  - cmd_en at T+22 → accepted.
- Aliasing and alignment:
  - Write at addr 21'h400 + 3 (MEM_AW=10) → data lands at words 0..7.
  - Read of addr 0 returns it.
- Reset mid-read:
  - Assert rst at T+14 of a read → rd_data_valid=0 from T+15.
  - init_calib=0 and rises again 64 cycles after release.
  - Memory contents are unchanged.
